// File: rtl/axis_param_fifo.sv
// axis_param_fifo: synchronous AXI4-Stream FIFO with package-driven sideband widths.
// Optional store-and-forward packet mode: define AXIS_PARAM_FIFO_PACKET_MODE_EN.
// Without the macro the FIFO is cut-through (m_axis_tvalid = !empty).

package axis_pkg;

    typedef struct packed {
        int unsigned TDATA_BYTES;
        int unsigned TID_WIDTH;
        int unsigned TDEST_WIDTH;
        int unsigned TUSER_WIDTH;
    } axis_parameters_t;

    localparam axis_parameters_t AXIS_PARAMETERS_DEFAULT = '{
        TDATA_BYTES: 4,
        TID_WIDTH:   4,
        TDEST_WIDTH: 4,
        TUSER_WIDTH: 4
    };

endpackage

module axis_param_fifo #(
    parameter axis_pkg::axis_parameters_t AXIS_PARAMETERS = axis_pkg::AXIS_PARAMETERS_DEFAULT,
    parameter int unsigned DEPTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,

    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic [8*AXIS_PARAMETERS.TDATA_BYTES-1:0]   s_axis_tdata,
    input  logic [AXIS_PARAMETERS.TDATA_BYTES-1:0]     s_axis_tkeep,
    input  logic                                       s_axis_tlast,
    input  logic [AXIS_PARAMETERS.TID_WIDTH-1:0]       s_axis_tid,
    input  logic [AXIS_PARAMETERS.TDEST_WIDTH-1:0]     s_axis_tdest,
    input  logic [AXIS_PARAMETERS.TUSER_WIDTH-1:0]     s_axis_tuser,

    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic [8*AXIS_PARAMETERS.TDATA_BYTES-1:0]   m_axis_tdata,
    output logic [AXIS_PARAMETERS.TDATA_BYTES-1:0]     m_axis_tkeep,
    output logic                                       m_axis_tlast,
    output logic [AXIS_PARAMETERS.TID_WIDTH-1:0]       m_axis_tid,
    output logic [AXIS_PARAMETERS.TDEST_WIDTH-1:0]     m_axis_tdest,
    output logic [AXIS_PARAMETERS.TUSER_WIDTH-1:0]     m_axis_tuser,

    output logic [$clog2(DEPTH):0]                     count
);

    localparam int unsigned B  = AXIS_PARAMETERS.TDATA_BYTES;
    localparam int unsigned I  = AXIS_PARAMETERS.TID_WIDTH;
    localparam int unsigned D  = AXIS_PARAMETERS.TDEST_WIDTH;
    localparam int unsigned U  = AXIS_PARAMETERS.TUSER_WIDTH;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned C  = AW + 1;
    localparam int unsigned PW = 8*B + B + 1 + I + D + U;

    logic [PW-1:0] mem_q [DEPTH];

    logic [C-1:0]  wr_ptr_q, wr_ptr_d;
    logic [C-1:0]  rd_ptr_q, rd_ptr_d;
    logic [C-1:0]  count_q, count_d;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [PW-1:0] s_payload;
    logic [PW-1:0] rd_payload;

    assign s_payload  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                         s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign rd_payload = mem_q[rd_ptr_q[AW-1:0]];

`ifdef AXIS_PARAM_FIFO_PACKET_MODE_EN
    logic [C-1:0]  pkt_cnt_q, pkt_cnt_d;
`endif

    // Status flags, handshakes and registered-state next values
    always_comb begin
        empty         = (wr_ptr_q == rd_ptr_q);
        full          = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
        s_axis_tready = !full && !rst;
`ifdef AXIS_PARAM_FIFO_PACKET_MODE_EN
        // The full term lets packets longer than DEPTH stream instead of deadlocking
        m_axis_tvalid = !empty && ((pkt_cnt_q != '0) || full);
`else
        m_axis_tvalid = !empty;
`endif
        push = s_axis_tvalid && s_axis_tready;
        pop  = m_axis_tvalid && m_axis_tready;

        {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
         m_axis_tid, m_axis_tdest, m_axis_tuser} = m_axis_tvalid ? rd_payload : '0;

        wr_ptr_d = wr_ptr_q + C'(push);
        rd_ptr_d = rd_ptr_q + C'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

`ifdef AXIS_PARAM_FIFO_PACKET_MODE_EN
        pkt_cnt_d = pkt_cnt_q;
        case ({push && s_axis_tlast, pop && m_axis_tlast})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
`endif
    end

    assign count = count_q;

    // Storage write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_payload;
        end
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef AXIS_PARAM_FIFO_PACKET_MODE_EN
    // Count of complete packets currently stored
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`endif

endmodule
